// File: rtl/share_event_trigger.sv
// share_event_trigger: turns found-share strobes into spaced fader trigger pulses.
// Keeps a saturating pending queue, a 32-bit share total and a sticky drop flag.
module share_event_trigger #(
    parameter int MINERS         = 1,
    parameter int PEND_BITS      = 4,
    parameter int PULSE_CYCLES   = 1,
    parameter int HOLDOFF_CYCLES = 2**22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MINERS-1:0]    found,
    output logic                 trigger,
    output logic [PEND_BITS-1:0] pending,
    output logic [31:0]          total,
    output logic                 dropped
);

    localparam int MAXC = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                          PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam int SW   = PEND_BITS + 5;

    localparam logic [TW-1:0]        PULSE_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]        HOLD_LD  = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [PEND_BITS-1:0] PMAX     = '1;
    localparam logic [SW-1:0]        PMAX_W   = SW'(PMAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PEND_BITS-1:0] pending_q, pending_d;
    logic [31:0]          total_q, total_d;
    logic                 dropped_q, dropped_d;
    logic                 trig_q, trig_d;
    logic [SW-1:0]        n;
    logic [SW-1:0]        sum;
    logic                 consume;

    // Count how many miners reported a share this cycle.
    always_comb begin
        n = '0;
        for (int i = 0; i < MINERS; i++) begin
            n = n + SW'(found[i]);
        end
    end

    // Pulse/holdoff sequencer; consumes one pending event when leaving IDLE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        consume = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d = PULSE;
                    timer_d = PULSE_LD;
                    consume = 1'b1;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = HOLDOFF;
                    timer_d = HOLD_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        trig_d = (state_d == PULSE);
    end

    // Pending queue with saturation, drop flag and wrapping total.
    always_comb begin
        sum       = SW'(pending_q) + n - SW'(consume);
        pending_d = pending_q;
        dropped_d = dropped_q;
        total_d   = total_q + 32'(n);
        if (sum > PMAX_W) begin
            pending_d = PMAX;
            dropped_d = 1'b1;
        end else begin
            pending_d = sum[PEND_BITS-1:0];
        end
    end

    // State and counter registers; reset discards same-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            total_q   <= '0;
            dropped_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            total_q   <= total_d;
            dropped_q <= dropped_d;
            trig_q    <= trig_d;
        end
    end

    assign trigger = trig_q;
    assign pending = pending_q;
    assign total   = total_q;
    assign dropped = dropped_q;

endmodule
